// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - mux select/sample and frame handshake bundle for mux_scan_ctrl
interface mux_scan_ctrl_if;
    logic [1:0] sel;
    logic       y_in;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;

    // master: the scan controller; slave: the mux plus the frame consumer
    modport master (
        output sel,
        output frame,
        output frame_valid,
        input  y_in,
        input  frame_ready
    );

    modport slave (
        input  sel,
        input  frame,
        input  frame_valid,
        output y_in,
        output frame_ready
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans a 4:1 mux, dwelling per channel, and assembles 4-bit frames
module mux_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            ovr_clr,
    output logic            overrun,
    mux_scan_ctrl_if.master bus
);
    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    sel_q;
    logic [3:0]    shadow;
    logic [3:0]    frame_q;
    logic          valid_q;
    logic          overrun_q;

    logic capture;
    logic frame_done;
    logic slot_free;
    logic drop;

    // A capture happens only on a live SCAN edge; dropping enable pre-empts it.
    assign capture    = (state == SCAN) && enable && (cnt == CNT_LAST);
    assign frame_done = capture && (sel_q == 2'd3);
    // The slot can take a new word if empty or being drained on this same edge.
    assign slot_free  = !valid_q || bus.frame_ready;
    assign drop       = frame_done && !slot_free;

    assign bus.sel         = sel_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = valid_q;
    assign overrun         = overrun_q;

    // Scan FSM: dwell counter, channel select and partial-frame shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel_q  <= 2'd0;
            shadow <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    sel_q <= 2'd0;
                    if (enable) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        sel_q  <= 2'd0;
                        shadow <= 4'b0000;
                    end else if (cnt == CNT_LAST) begin
                        shadow[sel_q] <= bus.y_in;
                        cnt           <= '0;
                        sel_q         <= sel_q + 2'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    sel_q <= 2'd0;
                end
            endcase
        end
    end

    // Output slot: load a completed frame when free, otherwise hold; clear on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 4'b0000;
            valid_q <= 1'b0;
        end else if (frame_done && slot_free) begin
            frame_q <= {bus.y_in, shadow[2:0]};
            valid_q <= 1'b1;
        end else if (valid_q && bus.frame_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl
module tb_mux_scan_ctrl;
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       ovr_clr;
    logic       overrun;
    logic [3:0] x;

    int errors;
    int checks;

    mux_scan_ctrl_if bus ();

    assign bus.y_in = x[bus.sel];

    mux_scan_ctrl #(.DWELL(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .ovr_clr (ovr_clr),
        .overrun (overrun),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle at the following falling edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        ovr_clr = 1'b0;
        bus.frame_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        ovr_clr = 1'b0;
        bus.frame_ready = 1'b0;
        x = 4'b0000;
        tick(2);
        checks++;
        if ({bus.sel, bus.frame, bus.frame_valid, overrun} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%0d frame=%b valid=%b ovr=%b, want all 0",
                     bus.sel, bus.frame, bus.frame_valid, overrun);
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if ({bus.sel, bus.frame_valid} !== 3'b000) begin
            errors++;
            $display("FAIL idle_hold: got sel=%0d valid=%b, want 0 0", bus.sel, bus.frame_valid);
        end
    endtask

    // sel order 0,1,2,3 held 4 cycles each, frame 1010 after S0+16
    task automatic test_scan_order();
        x = 4'b1010;
        enable = 1'b1;
        tick(1);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.sel !== 2'(k / 4) || bus.frame_valid !== 1'b0) begin
                errors++;
                $display("FAIL scan_sel@S0+%0d: got sel=%0d valid=%b, want sel=%0d valid=0",
                         k, bus.sel, bus.frame_valid, k / 4);
            end
            tick(1);
        end
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame !== 4'b1010 || bus.sel !== 2'd0) begin
            errors++;
            $display("FAIL first_frame: got valid=%b frame=%b sel=%0d, want 1 1010 0",
                     bus.frame_valid, bus.frame, bus.sel);
        end
    endtask

    // second frame completes at S0+32 with the slot still full
    task automatic test_overrun();
        x = 4'b0101;
        tick(15);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early@S0+31: got %b, want 0", overrun);
        end
        tick(1);
        checks++;
        if (overrun !== 1'b1 || bus.frame !== 4'b1010 || bus.frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set@S0+32: got ovr=%b frame=%b valid=%b, want 1 1010 1",
                     overrun, bus.frame, bus.frame_valid);
        end
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || bus.frame !== 4'b1010) begin
            errors++;
            $display("FAIL overrun_clear: got ovr=%b frame=%b, want 0 1010", overrun, bus.frame);
        end
    endtask

    // clear and new overrun on the same edge (S0+48): set wins
    task automatic test_ovr_clr_collision();
        tick(14);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1 || bus.frame !== 4'b1010) begin
            errors++;
            $display("FAIL ovr_set_wins: got ovr=%b frame=%b, want 1 1010", overrun, bus.frame);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat [3];
        pat[0] = 4'b0001;
        pat[1] = 4'b1000;
        pat[2] = 4'b1111;
        do_reset();
        bus.frame_ready = 1'b1;
        x = pat[0];
        enable = 1'b1;
        tick(1);
        for (int f = 0; f < 3; f++) begin
            tick(15);
            checks++;
            if (bus.frame_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_pre%0d: got valid=%b, want 0", f, bus.frame_valid);
            end
            tick(1);
            checks++;
            if (bus.frame_valid !== 1'b1 || bus.frame !== pat[f] || overrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b_frame%0d: got valid=%b frame=%b ovr=%b, want 1 %b 0",
                         f, bus.frame_valid, bus.frame, overrun, pat[f]);
            end
            if (f < 2) x = pat[f + 1];
        end
        tick(1);
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.frame !== 4'b1111) begin
            errors++;
            $display("FAIL b2b_drain: got valid=%b frame=%b, want 0 1111",
                     bus.frame_valid, bus.frame);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        x = 4'b1111;
        enable = 1'b1;
        tick(1);
        tick(9);
        checks++;
        if (bus.sel !== 2'd2) begin
            errors++;
            $display("FAIL drop_pre@S0+9: got sel=%0d, want 2", bus.sel);
        end
        enable = 1'b0;
        tick(1);
        checks++;
        if (bus.sel !== 2'd0 || bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got sel=%0d valid=%b, want 0 0", bus.sel, bus.frame_valid);
        end
        tick(6);
        checks++;
        if (bus.sel !== 2'd0 || bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_stay_idle: got sel=%0d valid=%b, want 0 0",
                     bus.sel, bus.frame_valid);
        end
        x = 4'b0100;
        enable = 1'b1;
        tick(1);
        tick(15);
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reenable_early: got valid=%b, want 0", bus.frame_valid);
        end
        tick(1);
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame !== 4'b0100) begin
            errors++;
            $display("FAIL reenable_frame: got valid=%b frame=%b, want 1 0100",
                     bus.frame_valid, bus.frame);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        x = 4'b1111;
        enable = 1'b1;
        tick(1);
        tick(13);
        checks++;
        if (bus.sel !== 2'd3) begin
            errors++;
            $display("FAIL arst_pre@S0+13: got sel=%0d, want 3", bus.sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sel, bus.frame, bus.frame_valid, overrun} !== 8'h00) begin
            errors++;
            $display("FAIL arst_immediate: got sel=%0d frame=%b valid=%b ovr=%b, want all 0",
                     bus.sel, bus.frame, bus.frame_valid, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        tick(15);
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_no_stale: got valid=%b, want 0", bus.frame_valid);
        end
        tick(1);
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.frame !== 4'b1111) begin
            errors++;
            $display("FAIL arst_fresh_frame: got valid=%b frame=%b, want 1 1111",
                     bus.frame_valid, bus.frame);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_scan_order();
        test_overrun();
        test_ovr_clr_collision();
        test_back_to_back();
        test_enable_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
